sub_rr_arbiter: RTL and testbench
=================================

Name: sub_rr_arbiter

Overview:
- Shares one 32-bit subtract/overflow datapath (existing `sub_32bit`) between NUM_REQ requesters.
- Requesters present operand pairs on valid/ready handshakes. A round-robin arbiter grants one pair per cycle.
- The result, signed-overflow flag and requester ID are held in a single output register on a valid/ready response channel.
- Sits between the issue-side requesters and any consumer needing subtraction results, such as address/offset and compare units.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of requester ID (localparam; not overridable).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand-valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*32  minuends, requester i at [32*i+31:32*i].
- req_b  in  NUM_REQ*32  subtrahends, same packing.
- rsp_valid  out  1  result register holds valid data.
- rsp_ready  in  1  consumer accepts result.
- rsp_diff  out  32  a - b, modulo 2^32.
- rsp_overflow  out  1  two's-complement signed overflow of a - b.
- rsp_id  out  ID_W  index of the requester that issued this result.

Behaviour:
- Reset (async assert, sync-style deassert use by the consumer):
  - rsp_valid=0, rsp_diff=0, rsp_overflow=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst is high.
- Accept condition: can_accept = !rsp_valid | rsp_ready. The output register is empty or draining this cycle.
- Grant, combinational:
  - If can_accept and any req_valid, grant the first set req_valid[i] searching i = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[g]=1 only for the granted g. All others 0. If can_accept=0, all req_ready=0.
- Transfer: requester g transfers when req_valid[g] & req_ready[g]. On that edge:
  - rsp_diff <= a_g - b_g.
  - rsp_overflow <= (a_g[31]^b_g[31]) & (diff[31]^a_g[31]).
  - rsp_id <= g.
  - rsp_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: exactly 1 cycle from request transfer to rsp_valid.
- Throughput: 1 result/cycle while rsp_ready stays high. Back-to-back accept plus drain in the same cycle is required (no bubble).
- Drain without new grant: if rsp_valid & rsp_ready and no request is granted, then rsp_valid <= 0. Data fields hold their last value.
- Stall: rsp_valid & !rsp_ready means the output register holds all fields unchanged, req_ready=0, and rr_ptr holds.
- No request: rr_ptr holds. It changes only on a transfer.
- Fairness: a continuously asserted requester is granted within NUM_REQ accepting cycles.
- Requester protocol (checked by assertion, not by RTL):
  - req_valid, once high, must stay high with stable operands until accepted.
  - req_ready does not depend on req_valid of the same requester in a combinational loop beyond the grant logic.
- Reset mid-operation: any pending result is discarded (rsp_valid=0 immediately) and rr_ptr returns to 0.
- Arithmetic:
  - Wrap-around modulo 2^32. Unsigned borrow is not exported.
  - Overflow equals the sub_32bit definition. Operands are zero-extended only if NUM_REQ packing is misused, which is illegal.

Decomposition:
- Shared package `sub_arb_pkg`:
  - DATA_W=32 constant.
  - typedef `sub_rsp_t` {diff[31:0], overflow, id}.
  - function `rr_pick(valid, ptr)` returning the granted index.
- Sub-module: one instance of the existing `sub_32bit` on the muxed granted operands.
- Arbiter, mux and output register live in sub_rr_arbiter. No other sub-modules.

Test Plan:
- Reset then single request: req_valid=0001, a=0x0000_0005, b=0x0000_0003 -> next cycle rsp_valid=1, diff=0x0000_0002, ovf=0, id=0; rr_ptr=1.
- Signed overflow cases (one requester):
  - a=0x8000_0000, b=0x0000_0001 -> diff=0x7FFF_FFFF, ovf=1.
  - a=0x7FFF_FFFF, b=0xFFFF_FFFF -> diff=0x8000_0000, ovf=1.
  - a=0, b=1 -> diff=0xFFFF_FFFF, ovf=0.
- All four requesters continuously valid with rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle with no bubbles; rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0, rsp fields and rr_ptr frozen. Release -> grant resumes at rr_ptr.
- Wrap-around pointer: rr_ptr=3, req_valid=0101 -> grant 0, then rr_ptr=1 and the next grant is 2.
- Async reset asserted mid-stream with rsp_valid=1 -> rsp_valid drops without a clock edge. After deassert, the first grant goes to the lowest valid index ≥0.

Source files
------------

// File: rtl/sub_arb_pkg.sv
// Shared types and the round-robin pick function for the subtract arbiter.
// Widths are sized for the largest supported requester count (16).
package sub_arb_pkg;

  localparam int DATA_W   = 32;
  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef logic [MAX_REQ-1:0]  req_vec_t;
  typedef logic [MAX_ID_W-1:0] rr_idx_t;
  typedef logic [MAX_ID_W:0]   req_cnt_t;

  typedef struct packed {
    logic [DATA_W-1:0] diff;
    logic              overflow;
    rr_idx_t           id;
  } sub_rsp_t;

  // First set valid bit at or after ptr, wrapping at n; ptr < n is assumed.
  function automatic rr_idx_t rr_pick(input req_vec_t valid, input rr_idx_t ptr,
                                      input req_cnt_t n);
    rr_idx_t   pick;
    logic      found;
    req_cnt_t  idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + req_cnt_t'(k);
      if (idx >= n) idx = idx - n;
      if (!found && (req_cnt_t'(k) < n) && valid[idx[MAX_ID_W-1:0]]) begin
        pick  = idx[MAX_ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sub_rr_arbiter_if.sv
// Requester and response channels of the shared subtractor.
interface sub_rr_arbiter_if #(parameter int NUM_REQ = 4);
  import sub_arb_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_diff;
  logic                      rsp_overflow;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_diff, rsp_overflow, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_diff, rsp_overflow, rsp_id
  );

endinterface

// File: rtl/sub_32bit.sv
// 32-bit subtractor with two's-complement signed overflow flag.
module sub_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] diff_o,
  output logic        overflow_o
);

  assign diff_o     = a_i - b_i;
  assign overflow_o = (a_i[31] ^ b_i[31]) & (diff_o[31] ^ a_i[31]);

endmodule

// File: rtl/sub_rr_arbiter.sv
// Round-robin arbiter sharing one sub_32bit between NUM_REQ requesters,
// with a single-entry valid/ready output register.
module sub_rr_arbiter
  import sub_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  sub_rr_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  typedef logic [ID_W-1:0]    id_t;
  typedef logic [NUM_REQ-1:0] vec_t;

  id_t               rrPtr_q, rrPtr_d, grantIdx;
  logic              rspValid_q, rspValid_d;
  sub_rsp_t          rsp_q, rsp_d;
  logic              canAccept, grantEn;
  logic [DATA_W-1:0] opA, opB, diff;
  logic              overflow;

  // A grant is only offered when the output register can take the result.
  assign canAccept = !rspValid_q || bus.rsp_ready;
  assign grantEn   = canAccept && (|bus.req_valid) && !rst;
  assign grantIdx  = id_t'(rr_pick(req_vec_t'(bus.req_valid), rr_idx_t'(rrPtr_q),
                                   req_cnt_t'(NUM_REQ)));

  assign bus.req_ready = grantEn ? (vec_t'(1) << grantIdx) : '0;

  assign opA = bus.req_a[grantIdx*DATA_W +: DATA_W];
  assign opB = bus.req_b[grantIdx*DATA_W +: DATA_W];

  sub_32bit u_sub (
    .a_i        (opA),
    .b_i        (opB),
    .diff_o     (diff),
    .overflow_o (overflow)
  );

  always_comb begin
    rsp_d      = rsp_q;
    rspValid_d = rspValid_q;
    rrPtr_d    = rrPtr_q;
    if (grantEn) begin
      rsp_d.diff     = diff;
      rsp_d.overflow = overflow;
      rsp_d.id       = rr_idx_t'(grantIdx);
      rspValid_d     = 1'b1;
      rrPtr_d        = (grantIdx == id_t'(NUM_REQ - 1)) ? '0 : grantIdx + id_t'(1);
    end else if (bus.rsp_ready) begin
      rspValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q      <= '0;
      rspValid_q <= 1'b0;
      rrPtr_q    <= '0;
    end else begin
      rsp_q      <= rsp_d;
      rspValid_q <= rspValid_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign bus.rsp_valid    = rspValid_q;
  assign bus.rsp_diff     = rsp_q.diff;
  assign bus.rsp_overflow = rsp_q.overflow;
  assign bus.rsp_id       = id_t'(rsp_q.id);

endmodule

// File: tb/tb_sub_rr_arbiter.sv
// Directed self-checking bench for sub_rr_arbiter with four requesters.
module tb_sub_rr_arbiter;

  localparam int NUM_REQ = 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] expDiff [4] = '{32'h0000_0100, 32'h0000_00F1, 32'h0000_00E2, 32'h0000_00D3};

  sub_rr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  sub_rr_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [3:0] valid, input logic rspReady);
    bus.req_valid = valid;
    bus.rsp_ready = rspReady;
  endtask

  task automatic setOperands(input int idx, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*idx +: 32] = a;
    bus.req_b[32*idx +: 32] = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic [31:0] d,
                          input logic o, input logic [1:0] id);
    checkOutput({tag, "_valid"}, 32'(bus.rsp_valid), 32'(v));
    checkOutput({tag, "_diff"}, bus.rsp_diff, d);
    checkOutput({tag, "_ovf"}, 32'(bus.rsp_overflow), 32'(o));
    checkOutput({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    applyStimulus(4'b1111, 1'b0);
    #2;
    checkRsp("reset", 1'b0, 32'h0, 1'b0, 2'd0);
    checkOutput("reset_ready", 32'(bus.req_ready), 32'h0);
    tick;
    checkOutput("reset_ready_edge", 32'(bus.req_ready), 32'h0);
    checkOutput("reset_valid_edge", 32'(bus.rsp_valid), 32'h0);

    applyStimulus(4'b0000, 1'b1);
    #2 rst = 1'b0;

    // Single request from requester 0
    setOperands(0, 32'h0000_0005, 32'h0000_0003);
    applyStimulus(4'b0001, 1'b1);
    #1 checkOutput("single_ready", 32'(bus.req_ready), 32'h1);
    tick;
    checkRsp("single", 1'b1, 32'h0000_0002, 1'b0, 2'd0);
    applyStimulus(4'b0000, 1'b1);
    #1 checkOutput("idle_ready", 32'(bus.req_ready), 32'h0);
    tick;
    checkRsp("drain", 1'b0, 32'h0000_0002, 1'b0, 2'd0);

    // Overflow cases, pointer walks 1 -> 2 -> 3 -> 0
    setOperands(1, 32'h8000_0000, 32'h0000_0001);
    applyStimulus(4'b0010, 1'b1);
    #1 checkOutput("ovf_neg_ready", 32'(bus.req_ready), 32'h2);
    tick;
    checkRsp("ovf_neg", 1'b1, 32'h7FFF_FFFF, 1'b1, 2'd1);
    setOperands(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(4'b0100, 1'b1);
    #1 checkOutput("ovf_pos_ready", 32'(bus.req_ready), 32'h4);
    tick;
    checkRsp("ovf_pos", 1'b1, 32'h8000_0000, 1'b1, 2'd2);
    setOperands(3, 32'h0000_0000, 32'h0000_0001);
    applyStimulus(4'b1000, 1'b1);
    #1 checkOutput("minus_one_ready", 32'(bus.req_ready), 32'h8);
    tick;
    checkRsp("minus_one", 1'b1, 32'hFFFF_FFFF, 1'b0, 2'd3);

    // All requesters valid: grants 0,1,2,3,0,1 with no bubbles
    setOperands(0, 32'h0000_0100, 32'h0000_0000);
    setOperands(1, 32'h0000_0101, 32'h0000_0010);
    setOperands(2, 32'h0000_0102, 32'h0000_0020);
    setOperands(3, 32'h0000_0103, 32'h0000_0030);
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1 checkOutput("stream_ready", 32'(bus.req_ready), 32'h1 << (k % 4));
      tick;
      checkRsp("stream", 1'b1, expDiff[k % 4], 1'b0, 2'(k % 4));
    end

    // Backpressure: everything frozen, pointer parked at 2
    applyStimulus(4'b1111, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 checkOutput("stall_ready", 32'(bus.req_ready), 32'h0);
      tick;
      checkRsp("stall", 1'b1, 32'h0000_00F1, 1'b0, 2'd1);
    end
    applyStimulus(4'b1111, 1'b1);
    #1 checkOutput("resume_ready", 32'(bus.req_ready), 32'h4);
    tick;
    checkRsp("resume", 1'b1, 32'h0000_00E2, 1'b0, 2'd2);

    // Pointer at 3 with requesters 0 and 2 pending wraps to 0, then 2
    applyStimulus(4'b0101, 1'b1);
    #1 checkOutput("wrap0_ready", 32'(bus.req_ready), 32'h1);
    tick;
    checkRsp("wrap0", 1'b1, 32'h0000_0100, 1'b0, 2'd0);
    #1 checkOutput("wrap2_ready", 32'(bus.req_ready), 32'h4);
    tick;
    checkRsp("wrap2", 1'b1, 32'h0000_00E2, 1'b0, 2'd2);

    // Async reset mid-stream drops the pending result without a clock edge
    applyStimulus(4'b1111, 1'b1);
    #1 checkOutput("pre_rst_ready", 32'(bus.req_ready), 32'h8);
    tick;
    checkRsp("pre_rst", 1'b1, 32'h0000_00D3, 1'b0, 2'd3);
    #2 rst = 1'b1;
    #1;
    checkRsp("mid_rst", 1'b0, 32'h0, 1'b0, 2'd0);
    checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    #2;
    applyStimulus(4'b1010, 1'b1);
    rst = 1'b0;
    #1 checkOutput("post_rst_ready", 32'(bus.req_ready), 32'h2);
    tick;
    checkRsp("post_rst", 1'b1, 32'h0000_00F1, 1'b0, 2'd1);

    applyStimulus(4'b0000, 1'b1);
    tick;
    checkOutput("final_drain", 32'(bus.rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
